gtech_fd4_pipe: RTL
===================

// Module: gtech_fd4_pipe
// PURPOSE
//  Parametrised successor to the single-bit set-type D flop: a DEPTH-stage, WIDTH-bit
//  register pipeline with per-stage valid tags, stall, flush and serial scan access.
//  Used as a generic delay line / retiming register in GTECH-mapped datapaths.
//  Provides true and complement outputs (Q/QN) like the single-bit cell.
// PARAMETERS
//  WIDTH     1         data bits per stage (>=1)
//  DEPTH     2         number of register stages = latency in enabled cycles (>=1)
//  RESET_VAL all-ones  WIDTH-bit value loaded into every stage on SD (set-type default)
// PORTS
//  CP      in   1               clock; all state changes on posedge CP only
//  SD      in   1               synchronous active-high reset/set (sampled at posedge CP)
//  EN      in   1               advance pipeline one stage
//  FLUSH   in   1               clear all valid tags, data held
//  TE      in   1               scan enable: whole array shifts as one serial chain
//  TI      in   1               scan serial in
//  D       in   WIDTH           stage-0 data in
//  DV      in   1               valid tag accompanying D
//  Q       out  WIDTH           last-stage data
//  QN      out  WIDTH           ~Q, combinational from Q (no extra flop)
//  QV      out  1               last-stage valid tag
//  TO      out  1               scan serial out = MSB of last stage
//  COUNT   out  clog2(DEPTH+1)  number of valid stages currently held
// BEHAVIOUR
//  - One clock, one reset: CP, SD. SD is synchronous, active-high; no async paths.
//  - Priority at each posedge CP: SD > TE > FLUSH > EN > hold.
//  - SD=1: every stage <= RESET_VAL, all valid <= 0, COUNT <= 0. So after reset
//    Q=RESET_VAL, QN=~RESET_VAL, QV=0, TO=RESET_VAL[WIDTH-1], COUNT=0.
//  - TE=1: chain order stage0[0]..stage0[W-1], stage1[0]..stage[D-1][W-1];
//    TI -> stage0[0], each bit <= predecessor; valid tags and COUNT held. EN/FLUSH ignored.
//  - FLUSH=1 (TE=0): valid[*] <= 0, COUNT <= 0, data held. Concurrent EN ignored
//    (incoming DV dropped).
//  - EN=1: stage[0] <= D, valid[0] <= DV; stage[i] <= stage[i-1], valid[i] <= valid[i-1].
//    COUNT <= COUNT + DV - valid[DEPTH-1]  (in and out same cycle -> unchanged).
//  - EN=0, no higher event: full hold of data, valid, COUNT.
//  - Latency: D/DV presented with EN=1 appear on Q/QV after DEPTH enabled edges;
//    stalled (EN=0) cycles do not count.
//  - COUNT must always equal popcount(valid[]); never exceeds DEPTH, never underflows.
//  - DEPTH=1: behaves as a WIDTH-bit FD4 with sync set, enable, valid, scan.
//  - SD asserted mid-stream: in-flight data discarded, no partial shift that cycle.
//  - X on EN/TE/FLUSH while SD=1 must not affect state.
// STRUCTURE
//  - Shared package gtech_pkg: function clog2, default RESET_VAL helper (all ones of WIDTH).
//  - Sub-module gtech_fd4_stage: one WIDTH-bit stage + valid flop with inputs
//    sd/te/flush/en, parallel in, scan in; instantiated DEPTH times via generate.
//  - Top holds COUNT register, Q/QN/QV/TO output assignments.
// TESTING
//  1 W=8,D=3: SD=1 one edge -> Q=8'hFF, QN=8'h00, QV=0, COUNT=0.
//  2 EN=1, D=8'h11,22,33,44 DV=1 -> Q=8'h11 with QV=1 on 3rd edge, 22/33/44 follow,
//    COUNT steps 1,2,3,3,3.
//  3 Stall: EN=0 for 5 edges mid-stream -> Q, QV, COUNT frozen; resume gives same order.
//  4 FLUSH with EN=1, D=8'h55 -> QV=0 next edge, COUNT=0, Q unchanged, 8'h55 not captured.
//  5 TE=1, TI=1 then 0 for 24 edges after reset -> TO sequence matches 24-bit chain
//    model; valid tags and COUNT unchanged.
//  6 SD and TE and EN all 1 same edge -> reset wins: Q=8'hFF, COUNT=0.

Source files
------------

// File: rtl/gtech_pkg.sv
// Shared helpers for the GTECH-style register cells: width math, set-type reset
// value and the priority decode of the per-edge control inputs.
package gtech_pkg;

   localparam int MAX_WIDTH = 1024;

   // What a stage does on a clock edge when SD is low.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_FLUSH = 2'd2,
      OP_SCAN  = 2'd3
   } stage_op_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] all_ones();
      return '1;
   endfunction

   // Scan beats flush, flush beats a normal advance.
   function automatic stage_op_e decode_op(input logic te, input logic flush, input logic en);
      if (te)         return OP_SCAN;
      else if (flush) return OP_FLUSH;
      else if (en)    return OP_LOAD;
      else            return OP_HOLD;
   endfunction

endpackage

// File: rtl/gtech_fd4_stage.sv
// One WIDTH-bit pipeline stage with its valid tag, sync set, flush and scan shift.
module gtech_fd4_stage
   import gtech_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(all_ones())
) (
   input  logic             cp,
   input  logic             sd,
   input  logic             te,
   input  logic             flush,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   input  logic             dv,
   input  logic             si,
   output logic [WIDTH-1:0] q,
   output logic             qv
);

   stage_op_e        op;
   logic [WIDTH-1:0] scan_next;

   // Within a stage the scan chain runs from bit 0 up to the MSB.
   always_comb begin
      op           = decode_op(te, flush, en);
      scan_next    = q;
      scan_next[0] = si;
      for (int b = 1; b < WIDTH; b++) scan_next[b] = q[b-1];
   end

   always_ff @(posedge cp) begin
      if (sd) begin
         q  <= RESET_VAL;
         qv <= 1'b0;
      end else begin
         case (op)
            OP_SCAN:  q  <= scan_next;
            OP_FLUSH: qv <= 1'b0;
            OP_LOAD: begin
               q  <= d;
               qv <= dv;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/gtech_fd4_pipe.sv
// DEPTH-stage WIDTH-bit register pipeline with valid tags, stall, flush, scan
// and a running count of valid stages; Q/QN/QV/TO come from the last stage.
module gtech_fd4_pipe
   import gtech_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(all_ones()),
   localparam int              CW        = clog2(DEPTH + 1)
) (
   input  logic             CP,
   input  logic             SD,
   input  logic             EN,
   input  logic             FLUSH,
   input  logic             TE,
   input  logic             TI,
   input  logic [WIDTH-1:0] D,
   input  logic             DV,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QN,
   output logic             QV,
   output logic             TO,
   output logic [CW-1:0]    COUNT
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic             stage_v [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_next;
   stage_op_e        op;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] d_in;
      logic             dv_in;
      logic             si_in;

      // Stage 0 takes the external inputs; later stages chain from their predecessor.
      if (i == 0) begin : g_first
         assign d_in  = D;
         assign dv_in = DV;
         assign si_in = TI;
      end else begin : g_next
         assign d_in  = stage_q[i-1];
         assign dv_in = stage_v[i-1];
         assign si_in = stage_q[i-1][WIDTH-1];
      end

      gtech_fd4_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .cp    (CP),
         .sd    (SD),
         .te    (TE),
         .flush (FLUSH),
         .en    (EN),
         .d     (d_in),
         .dv    (dv_in),
         .si    (si_in),
         .q     (stage_q[i]),
         .qv    (stage_v[i])
      );
   end

   // The count tracks the tag entering minus the tag leaving, so it always
   // equals the number of valid stages without a popcount tree.
   always_comb begin
      count_next = count_q;
      op         = decode_op(TE, FLUSH, EN);
      case (op)
         OP_FLUSH: count_next = '0;
         OP_LOAD: begin
            if (DV && !stage_v[DEPTH-1])      count_next = count_q + CW'(1);
            else if (!DV && stage_v[DEPTH-1]) count_next = count_q - CW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CP) begin
      if (SD) count_q <= '0;
      else    count_q <= count_next;
   end

   assign Q     = stage_q[DEPTH-1];
   assign QN    = ~Q;
   assign QV    = stage_v[DEPTH-1];
   assign TO    = Q[WIDTH-1];
   assign COUNT = count_q;

endmodule
